alu_muldiv_seq: RTL and testbench

//  Parametrised iterative multiply/divide unit for the core ALU.

---
 rtl/alu_muldiv_seq_if.sv | 25 ++
 rtl/alu_muldiv_seq.sv | 144 ++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_seq_if.sv
// rtl/alu_muldiv_seq_if.sv - issue/result bundle between the execute stage and the mul/div unit
interface alu_muldiv_seq_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic [1:0]       i_op;
  logic             i_signed;
  logic             i_submit;
  logic             i_flush;
  logic             o_busy;
  logic             o_valid;
  logic [WIDTH-1:0] o_d;
  logic             o_dbz;

  modport master (
    output i_a, i_b, i_op, i_signed, i_submit, i_flush,
    input  o_busy, o_valid, o_d, o_dbz
  );

  modport slave (
    input  i_a, i_b, i_op, i_signed, i_submit, i_flush,
    output o_busy, o_valid, o_d, o_dbz
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// rtl/alu_muldiv_seq.sv - iterative signed/unsigned MUL/MULH/DIV/MOD, fixed WIDTH+2 cycle latency
module alu_muldiv_seq #(
  parameter int WIDTH = 16
) (
  input logic             i_clk,
  input logic             i_rst,
  alu_muldiv_seq_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [1:0]         op_q, op_d;
  logic               neg_q, neg_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH-1:0]   o_d_q, o_d_d;
  logic               o_dbz_q, o_dbz_d;
  logic               o_valid_q, o_valid_d;

  logic               sa, sb;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh, div_sub;
  logic [2*WIDTH-1:0] mul_next, div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    sa    = bus.i_signed & bus.i_a[WIDTH-1];
    sb    = bus.i_signed & bus.i_b[WIDTH-1];
    a_abs = sa ? -bus.i_a : bus.i_a;
    b_abs = sb ? -bus.i_b : bus.i_b;

    // Multiply: acc = {partial high, remaining multiplier}, shifted right each step.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend bits still to consume / quotient bits}.
    div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_sub  = div_sh - {1'b0, opnd_q};
    if (div_sh >= {1'b0, opnd_q}) begin
      div_next = {div_sub[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end

    prod_fix = neg_q ? -acc_q : acc_q;
    quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    op_d      = op_q;
    neg_d     = neg_q;
    dbz_d     = dbz_q;
    o_d_d     = o_d_q;
    o_dbz_d   = o_dbz_q;
    o_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.i_submit && !bus.i_flush) begin
          state_d = CALC;
          cnt_d   = '0;
          op_d    = bus.i_op;
          neg_d   = (bus.i_op == 2'b11) ? sa : (sa ^ sb);
          dbz_d   = bus.i_op[1] && (bus.i_b == '0);
          if (bus.i_op[1]) begin
            opnd_d = b_abs;
            acc_d  = {{WIDTH{1'b0}}, a_abs};
          end else begin
            opnd_d = a_abs;
            acc_d  = {{WIDTH{1'b0}}, b_abs};
          end
        end
      end
      CALC: begin
        if (bus.i_flush) begin
          state_d = IDLE;
        end else begin
          acc_d = op_q[1] ? div_next : mul_next;
          if (cnt_q == CW'(WIDTH-1)) begin
            state_d = FIX;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!bus.i_flush) begin
          o_valid_d = 1'b1;
          o_dbz_d   = dbz_q;
          case (op_q)
            2'b00:   o_d_d = prod_fix[WIDTH-1:0];
            2'b01:   o_d_d = prod_fix[2*WIDTH-1:WIDTH];
            2'b10:   o_d_d = dbz_q ? {WIDTH{1'b1}} : quo_fix;
            default: o_d_d = rem_fix;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      dbz_q     <= 1'b0;
      o_d_q     <= '0;
      o_dbz_q   <= 1'b0;
      o_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      dbz_q     <= dbz_d;
      o_d_q     <= o_d_d;
      o_dbz_q   <= o_dbz_d;
      o_valid_q <= o_valid_d;
    end
  end

  assign bus.o_busy  = (bus.i_submit && (state_q == IDLE)) || (state_q != IDLE);
  assign bus.o_valid = o_valid_q;
  assign bus.o_d     = o_d_q;
  assign bus.o_dbz   = o_dbz_q;
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb/tb_alu_muldiv_seq.sv - self-checking bench for alu_muldiv_seq against a transaction-level model
module tb_alu_muldiv_seq;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_muldiv_seq_if #(.WIDTH(W)) bus ();

  alu_muldiv_seq #(.WIDTH(W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference result straight from integer arithmetic: {dbz, d}.
  function automatic logic [W:0] ref_op(input logic [1:0] op, input logic sg,
                                        input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, p, q, r;
    logic [63:0] pv, qv, rv;
    sa = sg ? longint'($signed(a)) : longint'(a);
    sb = sg ? longint'($signed(b)) : longint'(b);
    p  = sa * sb;
    pv = p;
    case (op)
      2'b00: return {1'b0, pv[W-1:0]};
      2'b01: return {1'b0, pv[2*W-1:W]};
      default: begin
        if (b == '0) return (op == 2'b10) ? {1'b1, {W{1'b1}}} : {1'b1, a};
        q  = sa / sb;
        r  = sa % sb;
        qv = q;
        rv = r;
        return (op == 2'b10) ? {1'b0, qv[W-1:0]} : {1'b0, rv[W-1:0]};
      end
    endcase
  endfunction

  // Transaction model: an accepted op completes WIDTH+2 cycles after its submit cycle.
  int          cyc = 0;
  bit          pend = 1'b0;
  int          done_cyc = 0;
  logic [W-1:0] pend_d;
  logic        pend_dbz;
  logic        exp_valid = 1'b0;
  logic [W-1:0] exp_d = '0;
  logic        exp_dbz = 1'b0;

  always @(posedge clk) begin
    bit in_fl;
    in_fl = pend && (cyc < done_cyc);
    if (rst) begin
      pend      = 1'b0;
      exp_valid = 1'b0;
      exp_d     = '0;
      exp_dbz   = 1'b0;
    end else begin
      exp_valid = 1'b0;
      if (in_fl && bus.i_flush) begin
        pend = 1'b0;
      end else if (pend && (done_cyc == cyc + 1)) begin
        exp_valid = 1'b1;
        exp_d     = pend_d;
        exp_dbz   = pend_dbz;
        pend      = 1'b0;
      end
      if (!in_fl && bus.i_submit && !bus.i_flush) begin
        pend     = 1'b1;
        done_cyc = cyc + W + 2;
        {pend_dbz, pend_d} = ref_op(bus.i_op, bus.i_signed, bus.i_a, bus.i_b);
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("o_valid", 32'(bus.o_valid), 32'(exp_valid));
      check("o_busy",  32'(bus.o_busy),  32'((pend && (cyc < done_cyc)) || bus.i_submit));
      check("o_d",     32'(bus.o_d),     32'(exp_d));
      check("o_dbz",   32'(bus.o_dbz),   32'(exp_dbz));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Submits in the current cycle, scrambles operands afterwards, returns at the negedge of o_valid.
  task automatic run_op(input logic [1:0] op, input logic sg, input logic [W-1:0] a,
                        input logic [W-1:0] b, output logic [W-1:0] d, output logic dbz,
                        output int lat);
    #1;
    bus.i_op     = op;
    bus.i_signed = sg;
    bus.i_a      = a;
    bus.i_b      = b;
    bus.i_submit = 1'b1;
    lat = -1;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      step();
      if (k == 1) bus.i_submit = 1'b0;
      bus.i_a = W'($urandom);
      bus.i_b = W'($urandom);
      @(negedge clk);
      if (bus.o_valid) lat = k;
    end
    d   = bus.o_d;
    dbz = bus.o_dbz;
  endtask

  task automatic directed(input string name, input logic [1:0] op, input logic sg,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_res, input logic exp_z);
    logic [W-1:0] d;
    logic         z;
    int           lat;
    run_op(op, sg, a, b, d, z, lat);
    check({name, "_lat"}, 32'(lat), 32'(W + 2));
    check({name, "_d"},   32'(d),   32'(exp_res));
    check({name, "_dbz"}, 32'(z),   32'(exp_z));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 16'h8000;
      2:       return 16'hFFFF;
      3:       return 16'h0001;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int nvalid;
    rst          = 1'b1;
    bus.i_a      = '0;
    bus.i_b      = '0;
    bus.i_op     = 2'b00;
    bus.i_signed = 1'b0;
    bus.i_submit = 1'b0;
    bus.i_flush  = 1'b0;

    // Hand-computed values pin the reference model itself.
    check("ref_mulh_s", 32'(ref_op(2'b01, 1'b1, 16'hFFFE, 16'h0003)), 32'h0FFFF);
    check("ref_mod_s",  32'(ref_op(2'b11, 1'b1, 16'hFFF9, 16'h0002)), 32'h0FFFF);
    check("ref_div_ov", 32'(ref_op(2'b10, 1'b1, 16'h8000, 16'hFFFF)), 32'h08000);
    check("ref_mod_z",  32'(ref_op(2'b11, 1'b0, 16'h1234, 16'h0000)), 32'h11234);

    step();
    step();
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(bus.o_busy), 32'h0);
    check("rst_d",    32'(bus.o_d),    32'h0);

    // Second op is submitted in the o_valid cycle of the first.
    directed("mul_u",     2'b00, 1'b0, 16'h0007, 16'h0009, 16'h003F, 1'b0);
    directed("mulh_u_b2b",2'b01, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0);
    directed("mulh_s",    2'b01, 1'b1, 16'hFFFE, 16'h0003, 16'hFFFF, 1'b0);
    directed("mul_s",     2'b00, 1'b1, 16'hFFFE, 16'h0003, 16'hFFFA, 1'b0);
    directed("div_s",     2'b10, 1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 1'b0);
    directed("mod_s",     2'b11, 1'b1, 16'hFFF9, 16'h0002, 16'hFFFF, 1'b0);
    directed("div_u",     2'b10, 1'b0, 16'hFFF9, 16'h0002, 16'h7FFC, 1'b0);
    directed("div_z",     2'b10, 1'b0, 16'h1234, 16'h0000, 16'hFFFF, 1'b1);
    directed("mod_z",     2'b11, 1'b0, 16'h1234, 16'h0000, 16'h1234, 1'b1);
    directed("div_ov",    2'b10, 1'b1, 16'h8000, 16'hFFFF, 16'h8000, 1'b0);
    directed("mod_ov",    2'b11, 1'b1, 16'h8000, 16'hFFFF, 16'h0000, 1'b0);
    directed("mul_pre",   2'b00, 1'b0, 16'h0101, 16'h0003, 16'h0303, 1'b0);

    // Flush mid-op; a submit while busy at T+3 must not queue.
    #1;
    bus.i_op = 2'b00; bus.i_signed = 1'b0; bus.i_a = 16'h0003; bus.i_b = 16'h0005;
    bus.i_submit = 1'b1;
    step(); bus.i_submit = 1'b0;
    step();
    step(); bus.i_submit = 1'b1; bus.i_a = 16'h0011;
    step(); bus.i_submit = 1'b0;
    step(); bus.i_flush = 1'b1;
    step(); bus.i_flush = 1'b0;
    step();
    @(negedge clk);
    check("flush_busy",  32'(bus.o_busy),  32'h0);
    check("flush_valid", 32'(bus.o_valid), 32'h0);
    check("flush_d",     32'(bus.o_d),     32'h0303);
    nvalid = 0;
    for (int k = 0; k < 25; k++) begin
      step();
      @(negedge clk);
      if (bus.o_valid) nvalid++;
    end
    check("flush_no_valid", 32'(nvalid), 32'h0);

    // Reset at T+10 of an in-flight op.
    #1;
    bus.i_op = 2'b01; bus.i_a = 16'h1111; bus.i_b = 16'h2222; bus.i_submit = 1'b1;
    step(); bus.i_submit = 1'b0;
    for (int k = 2; k <= 10; k++) step();
    rst = 1'b1;
    step(); rst = 1'b0;
    @(negedge clk);
    check("rstmid_valid", 32'(bus.o_valid), 32'h0);
    check("rstmid_busy",  32'(bus.o_busy),  32'h0);
    check("rstmid_d",     32'(bus.o_d),     32'h0);
    check("rstmid_dbz",   32'(bus.o_dbz),   32'h0);

    // Random sweep: submits, flushes and operand churn every cycle, checked by the model.
    for (int k = 0; k < 4000; k++) begin
      step();
      bus.i_submit = ($urandom_range(0, 2) == 0);
      bus.i_flush  = ($urandom_range(0, 79) == 0);
      bus.i_op     = 2'($urandom);
      bus.i_signed = 1'($urandom);
      bus.i_a      = pick();
      bus.i_b      = pick();
    end
    step();
    bus.i_submit = 1'b0;
    bus.i_flush  = 1'b0;
    for (int k = 0; k < 25; k++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
